// File: rtl/go_jmp_seq_pkg.sv
// Shared definitions for the go/jump sequencer: the state encoding seen on state_o
// and the legality rule for the run-length/counter-width parameters.
package go_jmp_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  // The step counter must be able to hold RUN_LEN-1, and a run needs a penultimate step.
  function automatic bit params_legal(input int run_len, input int cnt_w);
    return (run_len >= 2) && (cnt_w >= 1) && (cnt_w < 31) && ((1 << cnt_w) >= run_len);
  endfunction

endpackage

// File: rtl/seq_step_counter.sv
// RUN step counter with clear/increment controls and terminal/penultimate flags.
// Increment saturates at RUN_LEN-1 so the count can never wrap through 2^CNT_W.
module seq_step_counter
  import go_jmp_seq_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int RUN_LEN = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             is_last,
  output logic             is_penult
);

  localparam logic [CNT_W-1:0] LAST_STEP   = CNT_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] PENULT_STEP = CNT_W'(RUN_LEN - 2);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc && (cnt_reg != LAST_STEP)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt       = cnt_reg;
  assign is_last   = (cnt_reg == LAST_STEP);
  assign is_penult = (cnt_reg == PENULT_STEP);

endmodule

// File: rtl/go_jmp_sequencer.sv
// Parametrised go/jump sequencer: IDLE -> ARM -> (HOLD) -> RUN for RUN_LEN steps,
// with jump restart, abort, optional repeat, and registered y/done pulses.
module go_jmp_sequencer
  import go_jmp_seq_pkg::*;
#(
  parameter int RUN_LEN  = 7,
  parameter int CNT_W    = 4,
  parameter bit ARM_WAIT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic               jmp,
  input  logic               abort,
  input  logic               repeat_en,
  output logic               y,
  output logic               done,
  output logic               busy,
  output logic [CNT_W-1:0]   step,
  output logic [STATE_W-1:0] state_o
);

  generate
    if (!params_legal(RUN_LEN, CNT_W)) begin : g_bad_params
      $error("go_jmp_sequencer: illegal RUN_LEN/CNT_W combination");
    end
  endgenerate

  state_t state_reg;
  state_t state_next;
  logic   y_reg;
  logic   y_next;
  logic   done_reg;
  logic   done_next;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_is_last;
  logic   cnt_is_penult;

  seq_step_counter #(
    .CNT_W   (CNT_W),
    .RUN_LEN (RUN_LEN)
  ) u_step_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .cnt       (step),
    .is_last   (cnt_is_last),
    .is_penult (cnt_is_penult)
  );

  // Priority is abort > jmp > everything else; the step counter is cleared on every
  // entry to RUN and on every exit from it, so step reads 0 outside RUN.
  always_comb begin
    state_next = state_reg;
    y_next     = 1'b0;
    done_next  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    if (abort && (state_reg != IDLE)) begin
      state_next = IDLE;
      cnt_clr    = 1'b1;
    end else begin
      unique case (state_reg)
        IDLE: begin
          cnt_clr = 1'b1;
          if (go && jmp) begin
            state_next = RUN;
            y_next     = 1'b1;
          end else if (go) begin
            state_next = ARM;
          end
        end
        ARM: begin
          cnt_clr = 1'b1;
          if (jmp) begin
            state_next = RUN;
            y_next     = 1'b1;
          end else if (ARM_WAIT) begin
            state_next = HOLD;
          end else begin
            state_next = RUN;
          end
        end
        HOLD: begin
          cnt_clr = 1'b1;
          if (jmp) begin
            state_next = RUN;
            y_next     = 1'b1;
          end
        end
        RUN: begin
          if (jmp) begin
            cnt_clr = 1'b1;
            y_next  = 1'b1;
          end else if (cnt_is_penult) begin
            cnt_inc = 1'b1;
            y_next  = 1'b1;
          end else if (cnt_is_last) begin
            cnt_clr   = 1'b1;
            done_next = 1'b1;
            if (!repeat_en) begin
              state_next = IDLE;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_clr    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      y_reg     <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      y_reg     <= y_next;
      done_reg  <= done_next;
    end
  end

  assign y       = y_reg;
  assign done    = done_reg;
  assign busy    = (state_reg != IDLE);
  assign state_o = state_reg;

endmodule

// File: tb/tb_go_jmp_sequencer.sv
// Directed bench for go_jmp_sequencer: default DUT, an ARM_WAIT=0 DUT for repeat/bypass,
// and a RUN_LEN=2/CNT_W=1 corner DUT, all sharing one set of control inputs.
module tb_go_jmp_sequencer;
  import go_jmp_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n, go, jmp, abort, repeat_en;

  logic       a_y, a_done, a_busy;
  logic [3:0] a_step;
  logic [1:0] a_state;
  logic       b_y, b_done, b_busy;
  logic [3:0] b_step;
  logic [1:0] b_state;
  logic       c_y, c_done, c_busy;
  logic [0:0] c_step;
  logic [1:0] c_state;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  go_jmp_sequencer #(.RUN_LEN(7), .CNT_W(4), .ARM_WAIT(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .go(go), .jmp(jmp), .abort(abort), .repeat_en(repeat_en),
    .y(a_y), .done(a_done), .busy(a_busy), .step(a_step), .state_o(a_state)
  );

  go_jmp_sequencer #(.RUN_LEN(7), .CNT_W(4), .ARM_WAIT(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .go(go), .jmp(jmp), .abort(abort), .repeat_en(repeat_en),
    .y(b_y), .done(b_done), .busy(b_busy), .step(b_step), .state_o(b_state)
  );

  go_jmp_sequencer #(.RUN_LEN(2), .CNT_W(1), .ARM_WAIT(1'b1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .go(go), .jmp(jmp), .abort(abort), .repeat_en(repeat_en),
    .y(c_y), .done(c_done), .busy(c_busy), .step(c_step), .state_o(c_state)
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int st, input int stp, input int yv, input int dn);
    check({tag, ".state"}, int'(a_state), st);
    check({tag, ".step"},  int'(a_step),  stp);
    check({tag, ".y"},     int'(a_y),     yv);
    check({tag, ".done"},  int'(a_done),  dn);
    check({tag, ".busy"},  int'(a_busy),  (st != 0) ? 1 : 0);
    $display("[TB] %s state=%0d step=%0d y=%0b done=%0b busy=%0b", tag, a_state, a_step, a_y, a_done, a_busy);
  endtask

  task automatic chk_b(input string tag, input int st, input int stp, input int yv, input int dn);
    check({tag, ".state"}, int'(b_state), st);
    check({tag, ".step"},  int'(b_step),  stp);
    check({tag, ".y"},     int'(b_y),     yv);
    check({tag, ".done"},  int'(b_done),  dn);
    $display("[TB] %s state=%0d step=%0d y=%0b done=%0b", tag, b_state, b_step, b_y, b_done);
  endtask

  task automatic chk_c(input string tag, input int st, input int stp, input int yv, input int dn);
    check({tag, ".state"}, int'(c_state), st);
    check({tag, ".step"},  int'(c_step),  stp);
    check({tag, ".y"},     int'(c_y),     yv);
    check({tag, ".done"},  int'(c_done),  dn);
    $display("[TB] %s state=%0d step=%0d y=%0b done=%0b", tag, c_state, c_step, c_y, c_done);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; go = 1'b0; jmp = 1'b0; abort = 1'b0; repeat_en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; jmp = 1'b0; abort = 1'b0; repeat_en = 1'b0;
    #12;
    chk_a("reset_a", 0, 0, 0, 0);
    chk_b("reset_b", 0, 0, 0, 0);
    chk_c("reset_c", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk_a("idle_after_reset", 0, 0, 0, 0);

    // go held without jmp: ARM, then HOLD forever
    go = 1'b1;
    tick(); chk_a("hold_arm", 1, 0, 0, 0);
    tick(); chk_a("hold_hold1", 2, 0, 0, 0);
    tick(); chk_a("hold_hold2", 2, 0, 0, 0);
    go = 1'b0;
    tick(); chk_a("hold_hold3", 2, 0, 0, 0);

    // full run from HOLD
    jmp = 1'b1;
    tick(); chk_a("run_s0", 3, 0, 1, 0);
    jmp = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick(); chk_a($sformatf("run_s%0d", i), 3, i, (i == 6) ? 1 : 0, 0);
    end
    tick(); chk_a("run_done", 0, 0, 0, 1);
    tick(); chk_a("run_idle", 0, 0, 0, 0);

    // go&jmp from IDLE: one-cycle latency, then held jmp keeps restarting
    go = 1'b1; jmp = 1'b1;
    tick(); chk_a("gojmp_s0", 3, 0, 1, 0);
    go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_a($sformatf("heldjmp_%0d", i), 3, 0, 1, 0);
    end
    jmp = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick(); chk_a($sformatf("adv_s%0d", i), 3, i, 0, 0);
    end
    jmp = 1'b1;
    tick(); chk_a("restart_s4", 3, 0, 1, 0);
    jmp = 1'b0;
    for (int i = 1; i <= 6; i++) tick();
    chk_a("term_s6", 3, 6, 1, 0);
    jmp = 1'b1;
    tick(); chk_a("term_jmp", 3, 0, 1, 0);

    // abort with jmp at step 3
    jmp = 1'b0;
    for (int i = 1; i <= 3; i++) tick();
    chk_a("pre_abort_s3", 3, 3, 0, 0);
    abort = 1'b1; jmp = 1'b1;
    tick(); chk_a("abort_jmp", 0, 0, 0, 0);
    jmp = 1'b0;

    // abort is ignored in IDLE, but wins from ARM
    go = 1'b1;
    tick(); chk_a("abort_idle_go", 1, 0, 0, 0);
    go = 1'b0;
    tick(); chk_a("abort_from_arm", 0, 0, 0, 0);
    abort = 1'b0;

    // asynchronous reset mid-cycle while y is high at the final step
    go = 1'b1; jmp = 1'b1;
    tick();
    go = 1'b0; jmp = 1'b0;
    for (int i = 1; i <= 6; i++) tick();
    chk_a("prerst_s6", 3, 6, 1, 0);
    #2 rst_n = 1'b0;
    #1 chk_a("async_rst", 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    tick(); chk_a("post_rst", 0, 0, 0, 0);

    // repeat mode with ARM bypass on DUT B
    do_reset();
    repeat_en = 1'b1; go = 1'b1;
    tick(); chk_b("rep_arm", 1, 0, 0, 0);
    go = 1'b0;
    tick(); chk_b("rep_s0", 3, 0, 0, 0);
    chk_a("arm_wait_hold", 2, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      tick(); chk_b($sformatf("rep_s%0d", i), 3, i, (i == 6) ? 1 : 0, 0);
    end
    tick(); chk_b("rep_wrap", 3, 0, 0, 1);
    for (int i = 1; i <= 3; i++) tick();
    chk_b("rep2_s3", 3, 3, 0, 0);
    repeat_en = 1'b0;
    for (int i = 4; i <= 6; i++) begin
      tick(); chk_b($sformatf("rep2_s%0d", i), 3, i, (i == 6) ? 1 : 0, 0);
    end
    tick(); chk_b("rep2_end", 0, 0, 0, 1);

    // RUN_LEN=2 corner on DUT C
    do_reset();
    go = 1'b1; jmp = 1'b1;
    tick(); chk_c("c_s0", 3, 0, 1, 0);
    go = 1'b0; jmp = 1'b0;
    tick(); chk_c("c_s1", 3, 1, 1, 0);
    tick(); chk_c("c_done", 0, 0, 0, 1);
    tick(); chk_c("c_idle", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
